q2_io_ctl: RTL and testbench
============================

// Module: q2_io_ctl
// PURPOSE
//  Memory-mapped console peripheral on the q2 CPU bus, downstream of the q2 core.
//  Bus writes to ADDR (0xFFF) are queued and replayed to an HD44780-style character LCD
//    (8-bit mode) with correct E-strobe and execution-time pacing.
//  Bus reads of ADDR return debounced, active-low keypad state plus a FIFO-full flag.
//  All other addresses are ignored; RAM decodes them.
// PARAMETERS
//  ADDR       12'hFFF  I/O address decoded on abus
//  FIFO_DEPTH 4        write-queue entries (power of 2, >=2)
//  SETUP_CYC  1        clk cycles rs/data valid before E rises
//  E_CYC      4        clk cycles E held high
//  CHAR_WAIT  4        cycles after E falls, normal command/data (>=37us @100kHz)
//  CMD_WAIT   160      cycles after E falls, clear/home (0x01/0x02, >=1.52ms)
//  INIT_WAIT  1500     cycles idle after reset before init sequence (>=15ms)
//  DEB_CYC    200      consecutive stable cycles to accept a key change
// PORTS
//  clk       in   1   system clock (same as q2 core)
//  rst       in   1   synchronous, active-high reset
//  abus      in   12  CPU address bus
//  dbus_in   in   12  CPU data bus, write data
//  dbus_out  out  12  read data; valid when dbus_oe=1
//  dbus_oe   out  1   = rdm & (abus==ADDR), combinational; top level tristates dbus
//  rdm       in   1   CPU read strobe
//  wrm       in   1   CPU write strobe (level; one write per rising edge)
//  keys_n    in   8   raw keypad lines, active-low, asynchronous
//  lcd_rs    out  1   LCD register select (1=data, 0=command)
//  lcd_e     out  1   LCD enable strobe
//  lcd_d     out  8   LCD data
//  overflow  out  1   sticky: a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: lcd_e=0, lcd_rs=0, lcd_d=0, overflow=0, FIFO empty, key state=8'hFF,
//    wrm_q=1 (a wrm already high at reset release is not a write), FSM=INIT_DLY.
//  Write capture: wrm_q <= wrm every cycle; a write occurs when wrm & ~wrm_q & abus==ADDR.
//    Push dbus_in[8:0] in the same cycle. Full: drop the word, set overflow (cleared only by rst).
//    Push and pop in the same cycle on a full FIFO: the push is accepted.
//  Word decode: bit8=0 -> data write, rs=1, d=word[7:0].
//    bit8=1 -> command, rs=0, d=word[7:0] (0x80|a = set address, 0x01 = clear).
//    bits 11:9 are ignored.
//  Read: dbus_out = {full, 3'b111, key_state}. Reads have no side effects.
//  FSM states:
//    INIT_DLY: wait INIT_WAIT cycles.
//    INIT: emit the 4 ROM commands 0x38, 0x0C, 0x01, 0x06, each through SETUP/PULSE/WAIT.
//    IDLE: if FIFO non-empty, pop and go to SETUP.
//    SETUP: drive rs/d, e=0, for SETUP_CYC cycles.
//    PULSE: e=1 for E_CYC cycles; rs/d stable.
//    WAIT: e=0; rs/d held; wait CMD_WAIT if a command with d in {0x01,0x02}, else CHAR_WAIT.
//      Then return to INIT (if ROM not done) or IDLE.
//  Timing: a write to an empty FIFO in IDLE at cycle t gives SETUP at t+1 and E rising at
//    t+1+SETUP_CYC. Back-to-back spacing = SETUP_CYC+E_CYC+wait+1 (IDLE) cycles.
//  CPU writes during INIT_DLY/INIT are queued and sent after the init sequence.
//  Debounce: keys_n passes a 2-FF synchronizer, then a candidate register and a shared
//    counter. A change of the synced value reloads the candidate and zeroes the counter.
//    When the counter reaches DEB_CYC-1, key_state <= candidate. The counter saturates.
//  FIFO pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.
//  rst mid-transfer: lcd_e drops on the next edge and the init sequence restarts.
//    Pending FIFO words are discarded.
// STRUCTURE
//  q2_io_defs.vh: FSM state localparams, init ROM contents, and the CLEAR/HOME opcodes.
//  Sub-module q2_io_fifo (sync FIFO, WIDTH=9, DEPTH param, push/pop/full/empty).
//  The debouncer and LCD sequencer stay inline in q2_io_ctl.
// TESTING
//  1. Reset, then idle -> no E pulse for INIT_WAIT cycles; 4 E pulses with d=38,0C,01,06;
//     the gap after 0x01 is >=CMD_WAIT.
//  2. After init, write 0x041 to FFF -> exactly one E pulse with rs=1, d=0x41, E high E_CYC cycles.
//  3. Write 0x180 then 0x101 back-to-back -> rs=0 d=0x80 with a CHAR_WAIT gap,
//     then d=0x01 followed by a CMD_WAIT gap.
//  4. Six writes during INIT_DLY with DEPTH=4 -> first 4 emitted in order after init;
//     overflow=1; read of FFF shows bit11=1 while full.
//  5. keys_n bit2 glitches low for DEB_CYC-1 cycles -> read stays 0x7FF.
//     Held low for DEB_CYC+3 cycles -> read = 0x7FB.
//  6. Write to 0xFFE or hold wrm high across 10 cycles -> 0 or 1 queued word respectively.
//     Assert rst during PULSE -> lcd_e=0 next cycle.

Source files
------------

// File: rtl/q2_io_pkg.sv
// q2_io_pkg: shared definitions for the q2 console peripheral.
//   - LCD sequencer state encoding
//   - HD44780 init ROM and the slow (clear/home) opcodes
//   - helper deciding which wait period follows a word
package q2_io_pkg;

  typedef enum logic [2:0] {
    ST_INIT_DLY,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT
  } lcd_state_t;

  localparam int         WORD_W   = 9;   // {is_cmd, data[7:0]}
  localparam int         INIT_LEN = 4;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  // Power-up sequence: 8-bit/2-line, display on, clear, entry mode increment.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear and home need the long execution time; everything else is fast.
  function automatic logic is_slow_cmd(input logic [WORD_W-1:0] word);
    return word[8] && ((word[7:0] == OP_CLEAR) || (word[7:0] == OP_HOME));
  endfunction

endpackage

// File: rtl/q2_io_fifo.sv
// q2_io_fifo: synchronous FIFO for queued LCD words.
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request and data (accepted when not full, or when
//                 a pop happens in the same cycle)
//   pop, dout     read request and head-of-queue data (first-word fall-through)
//   full, empty   status from the extra pointer MSB
module q2_io_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/q2_io_ctl.sv
// q2_io_ctl: memory-mapped console peripheral on the q2 CPU bus.
//   clk, rst          system clock, synchronous active-high reset
//   abus              CPU address; only ADDR is decoded here
//   dbus_in           write data; bit8 selects command (1) or character (0)
//   dbus_out/dbus_oe  read data {fifo_full, 3'b111, key_state}; oe = rdm & hit
//   rdm, wrm          read strobe, write strobe (one write per rising edge)
//   keys_n            raw active-low keypad lines (asynchronous)
//   lcd_rs/e/d        HD44780 8-bit interface
//   overflow          sticky flag, set when a write is dropped on a full queue
module q2_io_ctl
  import q2_io_pkg::*;
#(
  parameter logic [11:0] ADDR       = 12'hFFF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          SETUP_CYC  = 1,
  parameter int          E_CYC      = 4,
  parameter int          CHAR_WAIT  = 4,
  parameter int          CMD_WAIT   = 160,
  parameter int          INIT_WAIT  = 1500,
  parameter int          DEB_CYC    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  input  logic [11:0] dbus_in,
  output logic [11:0] dbus_out,
  output logic        dbus_oe,
  input  logic        rdm,
  input  logic        wrm,
  input  logic [7:0]  keys_n,
  output logic        lcd_rs,
  output logic        lcd_e,
  output logic [7:0]  lcd_d,
  output logic        overflow
);

  localparam int CW = 16;                   // covers every timing parameter
  localparam int DW = $clog2(DEB_CYC) + 1;

  // ---------------- bus write capture ----------------
  logic              wrm_q;
  logic              wr_evt;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dout;
  logic              unused_hi_bits;

  assign wr_evt         = wrm & ~wrm_q & (abus == ADDR);
  assign unused_hi_bits = ^dbus_in[11:9];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrm_q    <= 1'b1;   // a strobe already high at reset release is not a write
      overflow <= 1'b0;
    end else begin
      wrm_q <= wrm;
      // A pop in the same cycle frees a slot, so the push is not dropped.
      if (wr_evt && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  q2_io_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_evt),
    .din   (dbus_in[8:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- keypad debounce ----------------
  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    cand;
  logic [7:0]    key_state;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 8'hFF;
      sync2     <= 8'hFF;
      cand      <= 8'hFF;
      key_state <= 8'hFF;
      deb_cnt   <= '0;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= '0;
      end else if (deb_cnt < DW'(DEB_CYC - 1)) begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      // Accept on the edge where the counter reaches DEB_CYC-1 (and stay
      // accepted while it sits saturated).
      if ((sync2 == cand) && (deb_cnt >= DW'(DEB_CYC - 2))) key_state <= cand;
    end
  end

  assign dbus_oe  = rdm & (abus == ADDR);
  assign dbus_out = {fifo_full, 3'b111, key_state};

  // ---------------- LCD sequencer ----------------
  lcd_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        rom_q, rom_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              e_q, e_d;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    rom_d    = rom_q;
    word_d   = word_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_INIT_DLY: begin
        if (cnt_q == CW'(INIT_WAIT - 1)) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      ST_INIT: begin
        word_d  = {1'b1, init_rom(rom_q[1:0])};
        rom_d   = rom_q + 3'd1;
        state_d = ST_SETUP;
        cnt_d   = '0;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_dout;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CW'(E_CYC - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == (is_slow_cmd(word_q) ? CW'(CMD_WAIT - 1) : CW'(CHAR_WAIT - 1))) begin
          state_d = (rom_q == 3'(INIT_LEN)) ? ST_IDLE : ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT_DLY;
        cnt_d   = '0;
      end
    endcase
    // E is registered from the next state so the strobe is glitch-free.
    e_d = (state_d == ST_PULSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT_DLY;
      cnt_q   <= '0;
      rom_q   <= '0;
      word_q  <= {1'b1, 8'h00};   // rs=0, d=0 while nothing has been sent
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rom_q   <= rom_d;
      word_q  <= word_d;
      e_q     <= e_d;
    end
  end

  assign lcd_e  = e_q;
  assign lcd_rs = ~word_q[8];
  assign lcd_d  = word_q[7:0];

endmodule

// File: tb/tb_q2_io_ctl.sv
module tb_q2_io_ctl;

  localparam int SETUP_CYC = 1;
  localparam int E_CYC     = 4;
  localparam int CHAR_WAIT = 4;
  localparam int CMD_WAIT  = 160;
  localparam int INIT_WAIT = 1500;
  localparam int DEB_CYC   = 200;
  localparam int CHAR_SPACING = SETUP_CYC + E_CYC + CHAR_WAIT + 1;
  localparam int CMD_SPACING  = SETUP_CYC + E_CYC + CMD_WAIT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] abus = 12'h000;
  logic [11:0] dbus_in = 12'h000;
  logic [11:0] dbus_out;
  logic        dbus_oe;
  logic        rdm = 1'b0;
  logic        wrm = 1'b0;
  logic [7:0]  keys_n = 8'hFF;
  logic        lcd_rs;
  logic        lcd_e;
  logic [7:0]  lcd_d;
  logic        overflow;

  q2_io_ctl #(
    .ADDR       (12'hFFF),
    .FIFO_DEPTH (4),
    .SETUP_CYC  (SETUP_CYC),
    .E_CYC      (E_CYC),
    .CHAR_WAIT  (CHAR_WAIT),
    .CMD_WAIT   (CMD_WAIT),
    .INIT_WAIT  (INIT_WAIT),
    .DEB_CYC    (DEB_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .abus     (abus),
    .dbus_in  (dbus_in),
    .dbus_out (dbus_out),
    .dbus_oe  (dbus_oe),
    .rdm      (rdm),
    .wrm      (wrm),
    .keys_n   (keys_n),
    .lcd_rs   (lcd_rs),
    .lcd_e    (lcd_e),
    .lcd_d    (lcd_d),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- E-pulse monitor ----------------
  int         ev_rise[$];
  int         ev_fall[$];
  int         ev_w[$];
  logic       ev_rs[$];
  logic [7:0] ev_d[$];
  bit         ev_unst[$];
  logic       e_prev = 1'b0;
  int         rise_c = 0;
  logic       rs_at = 1'b0;
  logic [7:0] d_at = 8'h00;
  bit         unst = 1'b0;

  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      rise_c = cyc;
      rs_at  = lcd_rs;
      d_at   = lcd_d;
      unst   = 1'b0;
    end else if (lcd_e && (lcd_rs !== rs_at || lcd_d !== d_at)) begin
      unst = 1'b1;
    end
    if (!lcd_e && e_prev) begin
      ev_rise.push_back(rise_c);
      ev_fall.push_back(cyc);
      ev_w.push_back(cyc - rise_c);
      ev_rs.push_back(rs_at);
      ev_d.push_back(d_at);
      ev_unst.push_back(unst);
    end
    e_prev = lcd_e;
  end

  // ---------------- helpers ----------------
  int n_checks = 0;
  int n_errs   = 0;
  int wr_cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [11:0] d);
    @(negedge clk);
    abus    = a;
    dbus_in = d;
    wrm     = 1'b1;
    @(negedge clk);
    wr_cyc = cyc;
    wrm    = 1'b0;
  endtask

  // Combinational read sampled mid-cycle; call right after a negedge.
  task automatic bus_read(input logic [11:0] a, output logic [11:0] val, output logic oe);
    abus = a;
    rdm  = 1'b1;
    #1;
    val = dbus_out;
    oe  = dbus_oe;
    rdm = 1'b0;
  endtask

  task automatic wait_events(input int n, input int budget, input string name);
    int k = 0;
    while (ev_d.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, ev_d.size() >= n, 1);
  endtask

  task automatic do_reset(output int rel);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
  endtask

  // Four ROM commands, correct pacing, first one only after the power-up delay.
  task automatic check_init(input int base, input int rel, input string tag);
    logic [7:0] rom [4];
    rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
    wait_events(base + 4, INIT_WAIT + 1000, {tag, "_init_timeout"});
    if (ev_d.size() >= base + 4) begin
      check({tag, "_init_delay_min"}, (ev_rise[base] - rel) >= INIT_WAIT, 1);
      check({tag, "_init_delay_max"}, (ev_rise[base] - rel) <= INIT_WAIT + 4, 1);
      for (int i = 0; i < 4; i++) begin
        check({tag, "_init_d"},  ev_d[base+i], rom[i]);
        check({tag, "_init_rs"}, ev_rs[base+i], 1'b0);
        check({tag, "_init_w"},  ev_w[base+i], E_CYC);
      end
      check({tag, "_init_sp01"}, ev_rise[base+1] - ev_rise[base],   CHAR_SPACING);
      check({tag, "_init_sp12"}, ev_rise[base+2] - ev_rise[base+1], CHAR_SPACING);
      check({tag, "_init_sp23"}, ev_rise[base+3] - ev_rise[base+2], CMD_SPACING);
      check({tag, "_clr_gap"},   (ev_rise[base+3] - ev_fall[base+2]) >= CMD_WAIT, 1);
    end
  endtask

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [11:0] data;
    bit          pulse;
    logic        rs;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int          rel;
    int          base;
    int          k;
    logic [11:0] rv;
    logic        roe;

    tbl[0] = '{"char_A",     12'hFFF, 12'h041, 1'b1, 1'b1, 8'h41};
    tbl[1] = '{"set_addr",   12'hFFF, 12'h180, 1'b1, 1'b0, 8'h80};
    tbl[2] = '{"clear",      12'hFFF, 12'h101, 1'b1, 1'b0, 8'h01};
    tbl[3] = '{"home",       12'hFFF, 12'h102, 1'b1, 1'b0, 8'h02};
    tbl[4] = '{"hi_ignored", 12'hFFF, 12'hE55, 1'b1, 1'b1, 8'h55};
    tbl[5] = '{"wrong_addr", 12'hFFE, 12'h041, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{"cmd_03",     12'hFFF, 12'h103, 1'b1, 1'b0, 8'h03};

    // ---- reset state and power-up sequence ----
    repeat (3) @(negedge clk);
    check("rst_lcd_e",  lcd_e, 1'b0);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_d",  lcd_d, 8'h00);
    check("rst_ovf",    overflow, 1'b0);
    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    bus_read(12'hFFF, rv, roe);
    check("rst_read", rv, 12'h7FF);
    check("rst_oe", roe, 1'b1);
    bus_read(12'hFFE, rv, roe);
    check("oe_other_addr", roe, 1'b0);
    abus = 12'hFFF;
    #1;
    check("oe_no_rdm", dbus_oe, 1'b0);
    check_init(0, rel, "por");
    repeat (CMD_WAIT + 20) @(negedge clk);

    // ---- table-driven single writes ----
    for (int i = 0; i < 7; i++) begin
      base = ev_d.size();
      bus_write(tbl[i].addr, tbl[i].data);
      if (tbl[i].pulse) begin
        wait_events(base + 1, 60, {tbl[i].name, "_timeout"});
        if (ev_d.size() > base) begin
          check({tbl[i].name, "_rs"},     ev_rs[base], tbl[i].rs);
          check({tbl[i].name, "_d"},      ev_d[base], tbl[i].d);
          check({tbl[i].name, "_width"},  ev_w[base], E_CYC);
          check({tbl[i].name, "_stable"}, ev_unst[base], 1'b0);
          check({tbl[i].name, "_lat"},    ev_rise[base] - wr_cyc, SETUP_CYC + 1);
        end
        repeat (CMD_WAIT + 20) @(negedge clk);
        check({tbl[i].name, "_count"}, ev_d.size(), base + 1);
      end else begin
        repeat (60) @(negedge clk);
        check({tbl[i].name, "_none"}, ev_d.size(), base);
      end
    end

    // ---- back-to-back: set address, clear, char ----
    base = ev_d.size();
    bus_write(12'hFFF, 12'h180);
    bus_write(12'hFFF, 12'h101);
    bus_write(12'hFFF, 12'h041);
    wait_events(base + 3, 400, "b2b_timeout");
    if (ev_d.size() >= base + 3) begin
      check("b2b_d0", {ev_rs[base],   ev_d[base]},   9'h080);
      check("b2b_d1", {ev_rs[base+1], ev_d[base+1]}, 9'h001);
      check("b2b_d2", {ev_rs[base+2], ev_d[base+2]}, 9'h141);
      check("b2b_char_gap", ev_rise[base+1] - ev_rise[base],   CHAR_SPACING);
      check("b2b_cmd_gap",  ev_rise[base+2] - ev_rise[base+1], CMD_SPACING);
    end
    repeat (50) @(negedge clk);

    // ---- wrm held high for 10 cycles: exactly one write ----
    base = ev_d.size();
    @(negedge clk);
    abus    = 12'hFFF;
    dbus_in = 12'h04A;
    wrm     = 1'b1;
    repeat (10) @(negedge clk);
    wrm = 1'b0;
    repeat (120) @(negedge clk);
    check("hold_count", ev_d.size(), base + 1);
    if (ev_d.size() > base) check("hold_d", ev_d[base], 8'h4A);

    // ---- overflow: six writes during the power-up delay ----
    do_reset(rel);
    base = ev_d.size();
    for (int i = 0; i < 4; i++) bus_write(12'hFFF, 12'h061 + 12'(i));
    check("full_no_ovf", overflow, 1'b0);
    bus_read(12'hFFF, rv, roe);
    check("full_read", rv, 12'hFFF);
    bus_write(12'hFFF, 12'h065);
    bus_write(12'hFFF, 12'h066);
    check("ovf_set", overflow, 1'b1);
    bus_read(12'hFFF, rv, roe);
    check("ovf_full_read", rv, 12'hFFF);
    check_init(base, rel, "ovf");
    wait_events(base + 8, 200, "ovf_drain_timeout");
    if (ev_d.size() >= base + 8)
      for (int i = 0; i < 4; i++)
        check("ovf_order", {ev_rs[base+4+i], ev_d[base+4+i]}, {1'b1, 8'h61 + 8'(i)});
    repeat (100) @(negedge clk);
    check("ovf_count", ev_d.size(), base + 8);
    bus_read(12'hFFF, rv, roe);
    check("drained_read", rv, 12'h7FF);
    check("ovf_sticky", overflow, 1'b1);

    // ---- debounce ----
    @(negedge clk);
    keys_n = 8'hFB;
    repeat (DEB_CYC - 1) @(negedge clk);
    keys_n = 8'hFF;
    repeat (20) @(negedge clk);
    bus_read(12'hFFF, rv, roe);
    check("deb_glitch", rv, 12'h7FF);
    @(negedge clk);
    keys_n = 8'hFB;
    repeat (DEB_CYC + 3) @(negedge clk);
    bus_read(12'hFFF, rv, roe);
    check("deb_press", rv, 12'h7FB);
    keys_n = 8'hFF;
    repeat (DEB_CYC + 10) @(negedge clk);
    bus_read(12'hFFF, rv, roe);
    check("deb_release", rv, 12'h7FF);

    // ---- reset during PULSE; queued words discarded ----
    bus_write(12'hFFF, 12'h042);
    bus_write(12'hFFF, 12'h043);
    bus_write(12'hFFF, 12'h044);
    k = 0;
    while (lcd_e !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("pulse_seen", lcd_e, 1'b1);
    check("ovf_before_rst", overflow, 1'b1);
    rst     = 1'b1;
    abus    = 12'hFFF;
    dbus_in = 12'h0AA;
    wrm     = 1'b1;
    @(negedge clk);
    check("rst_drops_e", lcd_e, 1'b0);
    check("rst_clr_ovf", overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    base = ev_d.size();
    repeat (5) @(negedge clk);
    wrm = 1'b0;
    bus_read(12'hFFF, rv, roe);
    check("rst_fifo_empty", rv, 12'h7FF);
    check_init(base, rel, "rst");
    repeat (300) @(negedge clk);
    check("rst_discard", ev_d.size(), base + 4);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
